// File: rtl/bsg_rr_lock_scheduler_pkg.sv
// ============================================================================
// Module : bsg_rr_lock_scheduler_pkg
// Brief  : Shared types and helpers for the round-robin lock scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bsg_rr_lock_scheduler_pkg;

    typedef enum logic [0:0] {
        eIdle = 1'b0,
        eLock = 1'b1
    } state_e;

    // A one-requester build still needs a 1-bit id.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int next_id(input int id, input int width);
        return (id + 1 >= width) ? 0 : id + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_rr_lock_scheduler_if.sv
// ============================================================================
// Module : bsg_rr_lock_scheduler_if
// Brief  : Requester-side and resource-side signals of the lock scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface bsg_rr_lock_scheduler_if #(
    parameter int width_p = 8
);
    import bsg_rr_lock_scheduler_pkg::*;

    localparam int id_width_lp = safe_clog2(width_p);

    logic [width_p-1:0]     v_i;
    logic [width_p-1:0]     last_i;
    logic [width_p-1:0]     yumi_o;
    logic                   v_o;
    logic [id_width_lp-1:0] id_o;
    logic                   last_o;
    logic                   ready_i;

    modport master (
        output v_i, last_i, ready_i,
        input  yumi_o, v_o, id_o, last_o
    );

    modport slave (
        input  v_i, last_i, ready_i,
        output yumi_o, v_o, id_o, last_o
    );

endinterface

`default_nettype wire

// File: rtl/bsg_rr_lock_scheduler_pick.sv
// ============================================================================
// Module : bsg_rr_lock_scheduler_pick
// Brief  : Round-robin pick: first valid requester after ptr_i, modulo width_p.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bsg_rr_lock_scheduler_pick
    import bsg_rr_lock_scheduler_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int id_width_lp = safe_clog2(width_p)
) (
    input  logic [width_p-1:0]     v_i,
    input  logic [id_width_lp-1:0] ptr_i,
    output logic [id_width_lp-1:0] sel_o,
    output logic                   any_o
);

    logic [id_width_lp-1:0] w_start;
    logic [width_p-1:0]     w_rot;
    logic [id_width_lp-1:0] w_ffs;
    int                     w_unrot;

    assign w_start = id_width_lp'(next_id(int'(ptr_i), width_p));

    // Rotating the doubled vector keeps the wrap at width_p, not 2**id_width_lp.
    assign w_rot = width_p'({v_i, v_i} >> w_start);
    assign any_o = |v_i;

    always_comb begin
        w_ffs = '0;
        for (int i = width_p - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_ffs = id_width_lp'(i);
            end
        end
    end

    always_comb begin
        w_unrot = int'(w_start) + int'(w_ffs);
        if (w_unrot >= width_p) begin
            w_unrot = w_unrot - width_p;
        end
    end

    assign sel_o = id_width_lp'(w_unrot);

endmodule

`default_nettype wire

// File: rtl/bsg_rr_lock_scheduler.sv
// ============================================================================
// Module : bsg_rr_lock_scheduler
// Brief  : Round-robin scheduler that holds the grant for multi-beat transfers.
//          Optional checks: BSG_RR_LOCK_SCHEDULER_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bsg_rr_lock_scheduler
    import bsg_rr_lock_scheduler_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bsg_rr_lock_scheduler_if.slave bus
);

    localparam int id_width_lp = safe_clog2(width_p);

    state_e                 state_q, state_d;
    logic [id_width_lp-1:0] ptr_q, ptr_d;
    logic [id_width_lp-1:0] lock_id_q, lock_id_d;

    logic [id_width_lp-1:0] w_pick_sel;
    logic                   w_pick_any;
    logic [id_width_lp-1:0] w_sel;
    logic                   w_v_raw;
    logic                   w_v;
    logic                   w_last;
    logic                   w_hs;

    bsg_rr_lock_scheduler_pick #(
        .width_p     (width_p),
        .id_width_lp (id_width_lp)
    ) u_pick (
        .v_i   (bus.v_i),
        .ptr_i (ptr_q),
        .sel_o (w_pick_sel),
        .any_o (w_pick_any)
    );

    // Other requesters are invisible while a transfer holds the lock.
    always_comb begin
        if (state_q == eLock) begin
            w_sel   = lock_id_q;
            w_v_raw = bus.v_i[lock_id_q];
        end else begin
            w_sel   = w_pick_sel;
            w_v_raw = w_pick_any;
        end
    end

    assign w_v    = w_v_raw & reset_n_i;
    assign w_last = w_v & bus.last_i[w_sel];
    assign w_hs   = w_v & bus.ready_i;

    assign bus.v_o    = w_v;
    assign bus.id_o   = w_v ? w_sel : '0;
    assign bus.last_o = w_last;
    assign bus.yumi_o = w_hs ? (width_p'(1) << w_sel) : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_id_d = lock_id_q;
        if (w_hs) begin
            case (state_q)
                eIdle: begin
                    if (w_last) begin
                        ptr_d = w_sel;
                    end else begin
                        state_d   = eLock;
                        lock_id_d = w_sel;
                    end
                end
                eLock: begin
                    if (w_last) begin
                        state_d = eIdle;
                        ptr_d   = lock_id_q;
                    end
                end
                default: begin
                    state_d = eIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= eIdle;
            ptr_q     <= id_width_lp'(width_p - 1);
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

`ifdef BSG_RR_LOCK_SCHEDULER_CHECK_EN
    if (width_p < 1) begin : g_width_check
        $error("bsg_rr_lock_scheduler: width_p must be at least 1");
    end

    logic chk_stall_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            chk_stall_q <= 1'b0;
        end else begin
            if (!$onehot0(bus.yumi_o)) begin
                $error("%0t: bsg_rr_lock_scheduler yumi_o not one-hot", $time);
            end
            if (chk_stall_q && (state_q == eLock) && !bus.v_i[lock_id_q]) begin
                $error("%0t: bsg_rr_lock_scheduler locked v_i fell while stalled", $time);
            end
            chk_stall_q <= (state_q == eLock) && w_v && !bus.ready_i;
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/bsg_rr_lock_scheduler.md
Name: bsg_rr_lock_scheduler

Overview:
- Round-robin scheduler that shares one downstream resource (e.g. a DPI host channel) among width_p requesters.
- Picks one requester per handshake and produces both a one-hot accept and a binary requester id.
- Holds the grant on one requester across a multi-beat transfer until that requester's last beat is accepted.
- Sits between per-tile request queues and the single shared link.

Parameters:
- width_p, 8, number of requesters (>=1, need not be a power of two).
- id_width_lp, BSG_SAFE_CLOG2(width_p), width of id_o (derived, not user-set).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  width_p  per-requester valid.
- last_i  in  width_p  per-requester "this beat is the final beat" flag; only meaningful where v_i is set.
- yumi_o  out  width_p  one-hot accept; bit k high means requester k's beat is consumed this cycle.
- v_o  out  1  a beat is presented to the resource.
- id_o  out  id_width_lp  binary index of the selected requester.
- last_o  out  1  last_i of the selected requester.
- ready_i  in  1  resource can accept a beat this cycle.

Behaviour:
- State registers:
  - ptr_r: id of the last requester that completed a transfer.
  - state_r: IDLE or LOCK.
  - lock_id_r: id of the requester holding the grant.
- Reset values: ptr_r = width_p-1, so requester 0 has first priority; state_r = IDLE; lock_id_r = 0.
- While reset_n_i is low: v_o, yumi_o, id_o and last_o are forced to 0.
- IDLE selection:
  - sel = first k with v_i[k]=1, scanning ptr_r+1, ptr_r+2, ... and wrapping modulo width_p (not modulo 2^id_width_lp).
  - v_o = |v_i.
- LOCK selection:
  - sel = lock_id_r; v_o = v_i[lock_id_r].
  - Requests from all other requesters are ignored.
- Outputs: id_o = sel when v_o=1, else 0; last_o = last_i[sel] & v_o.
- Handshake:
  - hs = v_o & ready_i.
  - yumi_o = hs ? (1<<sel) : 0; combinational, zero latency from v_i/ready_i.
  - At most one yumi_o bit is ever set.
- Transitions on a clock edge with hs=1:
  - IDLE, last_o=0: go to LOCK, lock_id_r <= sel.
  - IDLE, last_o=1 (single-beat transfer): stay IDLE, ptr_r <= sel.
  - LOCK, last_o=1: go to IDLE, ptr_r <= lock_id_r.
  - LOCK, last_o=0: stay in LOCK.
- hs=0: no state change. A locked requester may drop v_i between beats; the grant stays held, with no timeout.
- ready_i low with v_o high: selection and outputs stay stable while inputs are stable. The scheduler never withdraws a LOCK selection.
- width_p=1: id_o is always 0 and ptr_r wraps to 0; LOCK still applies.
- Asynchronous reset mid-transfer: returns immediately to IDLE with ptr_r = width_p-1. The partially sent transfer is abandoned; recovery is the requester's responsibility.

Optional Feature:
- Macro: BSG_RR_LOCK_SCHEDULER_CHECK_EN.
- When defined, simulation-only checks on every clock edge while out of reset, each raising $error with the cycle time:
  - yumi_o is zero or one-hot.
  - In LOCK, v_i of the locked requester must not fall while its beat was offered and ready_i was low.
  - v_i bits at indices >= width_p cannot exist (guarded by a parameter check at elaboration).
- When not defined, no checks and no extra logic; functional behaviour is identical.

Decomposition:
- Package bsg_rr_lock_scheduler_pkg:
  - typedef enum logic [0:0] {eIdle, eLock} for the state.
  - Function next_id(id, width) that performs the modulo-width increment.
- Sub-module bsg_rr_lock_scheduler_pick:
  - Combinational rotate-by-(ptr_r+1), find-first-set, then un-rotate back to a binary index.
  - Produces sel and an any-valid flag.
  - Instanced once; the top holds the FSM, registers and output gating.

Test Plan:
- Reset, width_p=4, v_i=4'b1111, last_i=4'b1111, ready_i=1 constant -> ids granted 0,1,2,3,0; exactly one yumi_o bit per cycle.
- width_p=4, requester 1 sends 3 beats (last only on beat 3) while v_i=4'b1111 -> id_o=1 for 3 consecutive handshakes, yumi_o=4'b0010 each time; next grant is id 2.
- LOCK on id 2 with ready_i=0 for 5 cycles, v_i[0] pulsing -> v_o=1, id_o=2, yumi_o=0 throughout; no switch to requester 0.
- width_p=5, only v_i[4] and v_i[0] set, single beats -> grants alternate 4,0,4,0, confirming the modulo-5 wrap.
- Assert reset_n_i low in LOCK mid-transfer, then release -> outputs 0 during reset; afterwards, with v_i=5'b11111, the first grant is id 0.
- width_p=1, v_i=1, last_i alternating -> id_o always 0; LOCK is entered and exited correctly.
